// File: rtl/neander_pkg.sv
`default_nettype none
// ============================================================================
// Module : neander_pkg
// Brief  : Shared neander types: loader states, default sync marker, opcodes.
// Rev    : 1.0
// ============================================================================
package neander_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_VERIFY = 3'd5,
        ST_RUN    = 3'd6
    } loader_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_STA = 8'h10;
    localparam logic [7:0] OP_LDA = 8'h20;
    localparam logic [7:0] OP_ADD = 8'h30;
    localparam logic [7:0] OP_OR  = 8'h40;
    localparam logic [7:0] OP_AND = 8'h50;
    localparam logic [7:0] OP_NOT = 8'h60;
    localparam logic [7:0] OP_JMP = 8'h80;
    localparam logic [7:0] OP_JN  = 8'h90;
    localparam logic [7:0] OP_JZ  = 8'hA0;
    localparam logic [7:0] OP_HLT = 8'hF0;

    // States in which the inter-byte watchdog is armed.
    function automatic logic is_timed_state(input loader_state_t s);
        return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/neander_loader_watchdog_timer.sv
`default_nettype none
// ============================================================================
// Module : watchdog_timer
// Brief  : Idle-cycle counter; o_expire flags the cycle that would reach TIMEOUT.
// Rev    : 1.0
// ============================================================================
module watchdog_timer #(
    parameter int TIMEOUT = 1000,
    parameter int TO_W    = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TO_W-1:0] c_last = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    // A clear in the same cycle always wins over expiry.
    assign o_expire = i_en && !i_clr && (r_count == c_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!i_en || i_clr || o_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TO_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/neander_loader.sv
`default_nettype none
// ============================================================================
// Module : neander_loader
// Brief  : Framed byte-stream loader for neander memory; holds the CPU in reset
//          until a frame passes its checksum.
// Rev    : 1.0
// ============================================================================
module neander_loader
    import neander_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT   = 1000,
    parameter int         TO_W      = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_mem_we,
    output logic [7:0] o_mem_addr,
    output logic [7:0] o_mem_wdata,
    output logic       o_cpu_rst,
    output logic       o_done,
    output logic       o_err
);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic [7:0] r_ptr;
    logic [7:0] r_acc;
    logic [8:0] r_count;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;
    logic       r_cpu_rst;
    logic       r_done;
    logic       r_err;

    logic       w_accept;
    logic       w_is_sync;
    logic       w_expire;
    logic       w_sum_ok;
    logic       w_done_set;
    logic       w_err_set;
    logic       w_enter_addr;
    logic [7:0] w_acc_add;

    assign o_ready      = (r_state != ST_VERIFY) && !i_rst;
    assign w_accept     = i_valid && o_ready;
    assign w_is_sync    = (i_data == SYNC_BYTE);
    assign w_sum_ok     = (r_acc == 8'd0);
    assign w_acc_add    = r_acc + i_data;
    assign w_enter_addr = (w_state_next == ST_ADDR) && (r_state != ST_ADDR);

    // Every entry into a timed state coincides with an accepted byte, so the
    // accept strobe alone also covers the clear-on-entry case.
    watchdog_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_accept),
        .i_en     (is_timed_state(r_state)),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_sync) w_state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (w_accept) begin
                    w_state_next = ST_LEN;
                end else if (w_expire) begin
                    w_state_next = ST_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    w_state_next = ST_DATA;
                end else if (w_expire) begin
                    w_state_next = ST_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    if (r_count == 9'd1) w_state_next = ST_CHK;
                end else if (w_expire) begin
                    w_state_next = ST_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            ST_CHK: begin
                if (w_accept) begin
                    w_state_next = ST_VERIFY;
                end else if (w_expire) begin
                    w_state_next = ST_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            ST_VERIFY: begin
                if (w_sum_ok) begin
                    w_state_next = ST_RUN;
                    w_done_set   = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_accept && w_is_sync) w_state_next = ST_ADDR;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= 8'd0;
            r_acc       <= 8'd0;
            r_count     <= 9'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= w_done_set;
            r_err    <= w_err_set;
            if (w_accept) begin
                case (r_state)
                    ST_ADDR: begin
                        r_ptr <= i_data;
                        r_acc <= i_data;
                    end
                    ST_LEN: begin
                        r_count <= (i_data == 8'd0) ? 9'd256 : {1'b0, i_data};
                        r_acc   <= w_acc_add;
                    end
                    ST_DATA: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_ptr;
                        r_mem_wdata <= i_data;
                        r_ptr       <= r_ptr + 8'd1;
                        r_count     <= r_count - 9'd1;
                        r_acc       <= w_acc_add;
                    end
                    ST_CHK: begin
                        r_acc <= w_acc_add;
                    end
                    default: begin
                    end
                endcase
            end
            // The CPU is only ever released by a successful checksum.
            if (w_enter_addr || w_err_set) begin
                r_cpu_rst <= 1'b1;
            end else if (w_done_set) begin
                r_cpu_rst <= 1'b0;
            end
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_rst   = r_cpu_rst;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_neander_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_neander_loader
// Brief  : Self-checking bench for neander_loader with a frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_neander_loader;
    import neander_pkg::*;

    localparam int TB_TIMEOUT = 50;
    localparam int TB_TO_W    = 6;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       o_ready;
    logic       o_mem_we;
    logic [7:0] o_mem_addr;
    logic [7:0] o_mem_wdata;
    logic       o_cpu_rst;
    logic       o_done;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] wq_addr[$];
    logic [7:0] wq_data[$];
    logic [7:0] exp_addr[$];
    logic [7:0] exp_data[$];
    logic [7:0] fr_data[$];
    int n_done       = 0;
    int n_err        = 0;
    bit both_seen    = 1'b0;
    bit done_rst_bad = 1'b0;
    bit err_rst_bad  = 1'b0;

    neander_loader #(
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TB_TIMEOUT),
        .TO_W      (TB_TO_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_cpu_rst   (o_cpu_rst),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    // Memory-port and pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (o_mem_we) begin
            wq_addr.push_back(o_mem_addr);
            wq_data.push_back(o_mem_wdata);
        end
        if (o_done) begin
            n_done++;
            if (o_cpu_rst !== 1'b0) done_rst_bad = 1'b1;
        end
        if (o_err) begin
            n_err++;
            if (o_cpu_rst !== 1'b1) err_rst_bad = 1'b1;
        end
        if (o_done && o_err) both_seen = 1'b1;
    end

    // Reference model: checksum byte that makes a frame valid.
    function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] len_field);
        int s;
        s = int'(addr) + int'(len_field);
        foreach (fr_data[i]) s += int'(fr_data[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Reference model: payload lands at consecutive addresses modulo 256.
    task automatic model_writes(input logic [7:0] addr);
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < fr_data.size(); i++) begin
            exp_addr.push_back(8'((int'(addr) + i) % 256));
            exp_data.push_back(fr_data[i]);
        end
    endtask

    function automatic int write_diffs();
        int d;
        d = 0;
        if (wq_addr.size() != exp_addr.size()) return -1;
        for (int i = 0; i < exp_addr.size(); i++)
            if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) d++;
        return d;
    endfunction

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 20) begin
            i_valid = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got=%b exp=1", o_ready);
        end
        i_valid = 1'b1;
        i_data  = b;
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic gap_send(input logic [7:0] b, input int max_gap);
        if (max_gap > 0) idle_cycles(int'($urandom_range(0, max_gap)));
        send_byte(b);
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] len_field,
                              input logic [7:0] chk, input int max_gap);
        send_byte(8'hA5);
        gap_send(addr, max_gap);
        gap_send(len_field, max_gap);
        for (int i = 0; i < fr_data.size(); i++) gap_send(fr_data[i], max_gap);
        gap_send(chk, max_gap);
    endtask

    task automatic test_reset();
        logic [20:0] got;
        logic [20:0] exp;
        @(negedge clk);
        got = {o_ready, o_cpu_rst, o_mem_we, o_done, o_err, o_mem_addr, o_mem_wdata};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", got, exp);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL post_reset ready=%b cpu_rst=%b exp 1 1", o_ready, o_cpu_rst);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] seq [0:6];
        int d0, e0, df;
        seq = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hE7};
        d0 = n_done; e0 = n_err;
        clear_writes();
        for (int i = 0; i < 7; i++) begin
            send_byte(seq[i]);
            #1;
            checks++;
            if (i >= 3 && i <= 5) begin
                if (o_mem_we !== 1'b1 || o_mem_addr !== 8'(8'h10 + i - 3) || o_mem_wdata !== seq[i]) begin
                    errors++;
                    $display("FAIL good_write_latency idx=%0d we=%b addr=%h data=%h exp 1 %h %h",
                             i, o_mem_we, o_mem_addr, o_mem_wdata, 8'(8'h10 + i - 3), seq[i]);
                end
            end else if (o_mem_we !== 1'b0) begin
                errors++;
                $display("FAIL good_no_write idx=%0d we=%b exp=0", i, o_mem_we);
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || o_done !== 1'b0 || o_cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL good_verify_cycle ready=%b done=%b cpu_rst=%b exp 0 0 1", o_ready, o_done, o_cpu_rst);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1 || o_cpu_rst !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL good_done_cycle done=%b cpu_rst=%b err=%b exp 1 0 0", o_done, o_cpu_rst, o_err);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL good_done_width done=%b exp=0", o_done);
        end
        idle_cycles(2);
        fr_data = '{8'h01, 8'h02, 8'h03};
        model_writes(8'h10);
        df = write_diffs();
        checks++;
        if (df != 0 || n_done - d0 != 1 || n_err != e0) begin
            errors++;
            $display("FAIL good_summary diffs=%0d done=%0d err=%0d exp 0 1 0", df, n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_bad_chk();
        int d0, e0, df;
        logic [7:0] a;
        d0 = n_done; e0 = n_err;
        clear_writes();
        fr_data = '{8'h01, 8'h02, 8'h03};
        model_writes(8'h10);
        send_frame(8'h10, 8'h03, 8'hE6, 0);
        idle_cycles(4);
        df = write_diffs();
        checks++;
        if (df != 0 || n_err - e0 != 1 || n_done != d0 || o_cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL bad_chk diffs=%0d err=%0d done=%0d cpu_rst=%b exp 0 1 0 1",
                     df, n_err - e0, n_done - d0, o_cpu_rst);
        end
        send_byte(8'h10);
        idle_cycles(3);
        checks++;
        if (wq_addr.size() != 3 || o_cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL bad_chk_idle writes=%0d cpu_rst=%b exp 3 1", wq_addr.size(), o_cpu_rst);
        end
        clear_writes();
        d0 = n_done; e0 = n_err;
        a = 8'($urandom);
        fr_data = '{8'($urandom), 8'($urandom), 8'($urandom)};
        model_writes(a);
        send_frame(a, 8'h03, frame_chk(a, 8'h03), 0);
        idle_cycles(4);
        df = write_diffs();
        checks++;
        if (df != 0 || n_done - d0 != 1 || n_err != e0 || o_cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL bad_then_good diffs=%0d done=%0d err=%0d cpu_rst=%b exp 0 1 0 0",
                     df, n_done - d0, n_err - e0, o_cpu_rst);
        end
    endtask

    task automatic test_wrap_len0();
        int d0, e0, df;
        d0 = n_done; e0 = n_err;
        clear_writes();
        fr_data.delete();
        for (int i = 0; i < 256; i++) fr_data.push_back(8'(i));
        model_writes(8'hFE);
        send_frame(8'hFE, 8'h00, frame_chk(8'hFE, 8'h00), 0);
        idle_cycles(4);
        df = write_diffs();
        checks++;
        if (df != 0 || n_done - d0 != 1 || n_err != e0 || o_cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL wrap_len0 diffs=%0d writes=%0d done=%0d err=%0d cpu_rst=%b exp 0 256 1 0 0",
                     df, wq_addr.size(), n_done - d0, n_err - e0, o_cpu_rst);
        end
    endtask

    task automatic test_timeout();
        int e0, df;
        bit early;
        e0 = n_err;
        early = 1'b0;
        clear_writes();
        fr_data = '{8'h55};
        model_writes(8'h20);
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h02); send_byte(8'h55);
        for (int k = 1; k <= TB_TIMEOUT + 1; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            if (k <= TB_TIMEOUT && o_err !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early || o_err !== 1'b1 || o_cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse early=%b err=%b cpu_rst=%b exp 0 1 1", early, o_err, o_cpu_rst);
        end
        send_byte(8'h66);
        idle_cycles(4);
        df = write_diffs();
        checks++;
        if (df != 0 || n_err - e0 != 1) begin
            errors++;
            $display("FAIL timeout_after diffs=%0d err=%0d exp 0 1", df, n_err - e0);
        end
    endtask

    task automatic test_timeout_edge();
        int d0, e0, df;
        d0 = n_done; e0 = n_err;
        clear_writes();
        fr_data = '{8'h55, 8'h66};
        model_writes(8'h20);
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h02); send_byte(8'h55);
        idle_cycles(TB_TIMEOUT - 1);
        send_byte(8'h66);
        #1;
        checks++;
        if (o_mem_we !== 1'b1 || o_mem_wdata !== 8'h66 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_edge_byte we=%b data=%h err=%b exp 1 66 0", o_mem_we, o_mem_wdata, o_err);
        end
        send_byte(frame_chk(8'h20, 8'h02));
        idle_cycles(4);
        df = write_diffs();
        checks++;
        if (df != 0 || n_done - d0 != 1 || n_err != e0) begin
            errors++;
            $display("FAIL timeout_edge_frame diffs=%0d done=%0d err=%0d exp 0 1 0", df, n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_async_reset();
        logic [20:0] got;
        logic [20:0] exp;
        int d0, df;
        clear_writes();
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        #1;
        checks++;
        if (o_mem_we !== 1'b1) begin
            errors++;
            $display("FAIL areset_pending_write we=%b exp=1", o_mem_we);
        end
        #1 rst = 1'b1;
        #1;
        got = {o_ready, o_cpu_rst, o_mem_we, o_done, o_err, o_mem_addr, o_mem_wdata};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL areset_outputs got=%h exp=%h", got, exp);
        end
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b0;
        idle_cycles(2);
        fr_data = '{8'h11};
        model_writes(8'h30);
        df = write_diffs();
        checks++;
        if (df != 0) begin
            errors++;
            $display("FAIL areset_dropped_write diffs=%0d writes=%0d exp 0 1", df, wq_addr.size());
        end
        clear_writes();
        d0 = n_done;
        fr_data = '{8'h99};
        model_writes(8'h40);
        send_frame(8'h40, 8'h01, frame_chk(8'h40, 8'h01), 0);
        idle_cycles(4);
        df = write_diffs();
        checks++;
        if (df != 0 || n_done - d0 != 1 || o_cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL areset_fresh_frame diffs=%0d done=%0d cpu_rst=%b exp 0 1 0", df, n_done - d0, o_cpu_rst);
        end
    endtask

    task automatic test_run_resync();
        int d0, df;
        clear_writes();
        d0 = n_done;
        send_byte(8'h77);
        idle_cycles(3);
        checks++;
        if (o_cpu_rst !== 1'b0 || wq_addr.size() != 0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_ignore cpu_rst=%b writes=%0d ready=%b exp 0 0 1", o_cpu_rst, wq_addr.size(), o_ready);
        end
        send_byte(8'hA5);
        #1;
        checks++;
        if (o_cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL run_resync_rst cpu_rst=%b exp=1", o_cpu_rst);
        end
        fr_data = '{8'hAB};
        model_writes(8'h50);
        send_byte(8'h50); send_byte(8'h01); send_byte(8'hAB);
        send_byte(frame_chk(8'h50, 8'h01));
        idle_cycles(4);
        df = write_diffs();
        checks++;
        if (df != 0 || n_done - d0 != 1 || o_cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL run_resync_frame diffs=%0d done=%0d cpu_rst=%b exp 0 1 0", df, n_done - d0, o_cpu_rst);
        end
    endtask

    task automatic test_random_gaps();
        int d0, e0, df, len;
        logic [7:0] a, chk;
        bit good;
        for (int f = 0; f < 12; f++) begin
            a   = 8'($urandom);
            len = int'($urandom_range(1, 16));
            fr_data.delete();
            for (int i = 0; i < len; i++) fr_data.push_back(8'($urandom));
            chk  = frame_chk(a, 8'(len));
            good = ($urandom_range(0, 3) != 0);
            if (!good) chk = chk + 8'($urandom_range(1, 255));
            clear_writes();
            d0 = n_done; e0 = n_err;
            model_writes(a);
            if ($urandom_range(0, 1) == 1) send_byte(8'h3C);
            send_frame(a, 8'(len), chk, (f % 3 == 0) ? TB_TIMEOUT - 1 : 4);
            idle_cycles(4);
            df = write_diffs();
            checks++;
            if (df != 0 || n_done - d0 != int'(good) || n_err - e0 != int'(!good) || o_cpu_rst !== !good) begin
                errors++;
                $display("FAIL random_frame f=%0d diffs=%0d done=%0d err=%0d cpu_rst=%b exp 0 %0d %0d %b",
                         f, df, n_done - d0, n_err - e0, o_cpu_rst, good, !good, !good);
            end
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (both_seen || done_rst_bad || err_rst_bad) begin
            errors++;
            $display("FAIL pulse_rules both=%b done_rst=%b err_rst=%b exp 0 0 0", both_seen, done_rst_bad, err_rst_bad);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_wrap_len0();
        test_timeout();
        test_timeout_edge();
        test_async_reset();
        test_run_resync();
        test_random_gaps();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
